// File: rtl/bus_arbiter.sv
// Two-master bus arbiter: fixed priority out of idle, burst-limited handover
// between owners, and a tagged return pipeline that steers read data back to
// the master that issued the read.
module bus_arbiter #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             m0_req,
  input  logic [WIDTH-1:0] m0_addr,
  input  logic             m0_we,
  input  logic [WIDTH-1:0] m0_wdata,
  output logic             m0_gnt,
  output logic             m0_rvalid,
  output logic [WIDTH-1:0] m0_rdata,
  input  logic             m1_req,
  input  logic [WIDTH-1:0] m1_addr,
  input  logic             m1_we,
  input  logic [WIDTH-1:0] m1_wdata,
  output logic             m1_gnt,
  output logic             m1_rvalid,
  output logic [WIDTH-1:0] m1_rdata,
  output logic [WIDTH-1:0] addr,
  output logic             we,
  output logic [WIDTH-1:0] wdata,
  input  logic [WIDTH-1:0] rdata
);

  localparam int unsigned BW = $clog2(MAX_BURST) + 1;
  localparam logic [BW-1:0] BMAX = BW'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [BW-1:0]   r_bcnt;
  logic [BW-1:0]   w_bcnt_nxt;
  logic            w_acc;
  logic            w_tag;
  logic [RD_LATENCY-1:0] r_pv;
  logic [RD_LATENCY-1:0] r_ptag;

  // State and burst counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_bcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_bcnt  <= w_bcnt_nxt;
    end
  end

  // Grants and bus drive, decoded from the registered owner
  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    addr   = '0;
    we     = 1'b0;
    wdata  = '0;
    w_acc  = 1'b0;
    w_tag  = 1'b0;
    case (r_state)
      OWN0: begin
        m0_gnt = m0_req;
        w_acc  = m0_req;
        if (m0_req) begin
          addr  = m0_addr;
          we    = m0_we;
          wdata = m0_wdata;
        end
      end
      OWN1: begin
        m1_gnt = m1_req;
        w_acc  = m1_req;
        w_tag  = 1'b1;
        if (m1_req) begin
          addr  = m1_addr;
          we    = m1_we;
          wdata = m1_wdata;
        end
      end
      default: ;
    endcase
  end

  // Next owner and burst count
  always_comb begin
    w_state_nxt = r_state;
    w_bcnt_nxt  = r_bcnt;
    case (r_state)
      IDLE: begin
        w_bcnt_nxt = '0;
        if (m0_req)      w_state_nxt = OWN0;
        else if (m1_req) w_state_nxt = OWN1;
      end
      OWN0: begin
        if (!m0_req) begin
          w_state_nxt = m1_req ? OWN1 : IDLE;
          w_bcnt_nxt  = '0;
        end else if (m1_req && (r_bcnt == BMAX)) begin
          w_state_nxt = OWN1;
          w_bcnt_nxt  = '0;
        end else if (r_bcnt != BMAX) begin
          w_bcnt_nxt = r_bcnt + BW'(1);
        end
      end
      OWN1: begin
        if (!m1_req) begin
          w_state_nxt = m0_req ? OWN0 : IDLE;
          w_bcnt_nxt  = '0;
        end else if (m0_req && (r_bcnt == BMAX)) begin
          w_state_nxt = OWN0;
          w_bcnt_nxt  = '0;
        end else if (r_bcnt != BMAX) begin
          w_bcnt_nxt = r_bcnt + BW'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_bcnt_nxt  = '0;
      end
    endcase
  end

  // Return pipeline: one {valid, tag} stage per cycle of read latency
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pv   <= '0;
      r_ptag <= '0;
    end else begin
      r_pv[0]   <= w_acc && !we;
      r_ptag[0] <= w_tag;
      for (int unsigned i = 1; i < RD_LATENCY; i++) begin
        r_pv[i]   <= r_pv[i-1];
        r_ptag[i] <= r_ptag[i-1];
      end
    end
  end

  // Steer bus read data to the tagged master
  always_comb begin
    m0_rvalid = r_pv[RD_LATENCY-1] && !r_ptag[RD_LATENCY-1];
    m1_rvalid = r_pv[RD_LATENCY-1] &&  r_ptag[RD_LATENCY-1];
    m0_rdata  = m0_rvalid ? rdata : '0;
    m1_rdata  = m1_rvalid ? rdata : '0;
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: a per-cycle vector table on the default
// configuration plus short sequences for latency 2 and burst limit 1.
module tb_bus_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
  logic [31:0] rdata = '0;

  logic a_g0, a_g1, a_v0, a_v1, a_we;
  logic [31:0] a_rd0, a_rd1, a_addr, a_wd;
  logic b_g0, b_g1, b_v0, b_v1, b_we;
  logic [31:0] b_rd0, b_rd1, b_addr, b_wd;
  logic c_g0, c_g1, c_v0, c_v1, c_we;
  logic [31:0] c_rd0, c_rd1, c_addr, c_wd;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bus_arbiter #(.WIDTH(32), .RD_LATENCY(1), .MAX_BURST(4)) dut_a (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_we(m0_we), .m0_wdata(m0_wdata),
    .m0_gnt(a_g0), .m0_rvalid(a_v0), .m0_rdata(a_rd0),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_wdata(m1_wdata),
    .m1_gnt(a_g1), .m1_rvalid(a_v1), .m1_rdata(a_rd1),
    .addr(a_addr), .we(a_we), .wdata(a_wd), .rdata(rdata)
  );

  bus_arbiter #(.WIDTH(32), .RD_LATENCY(2), .MAX_BURST(4)) dut_b (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_we(m0_we), .m0_wdata(m0_wdata),
    .m0_gnt(b_g0), .m0_rvalid(b_v0), .m0_rdata(b_rd0),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_wdata(m1_wdata),
    .m1_gnt(b_g1), .m1_rvalid(b_v1), .m1_rdata(b_rd1),
    .addr(b_addr), .we(b_we), .wdata(b_wd), .rdata(rdata)
  );

  bus_arbiter #(.WIDTH(32), .RD_LATENCY(1), .MAX_BURST(1)) dut_c (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_we(m0_we), .m0_wdata(m0_wdata),
    .m0_gnt(c_g0), .m0_rvalid(c_v0), .m0_rdata(c_rd0),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_wdata(m1_wdata),
    .m1_gnt(c_g1), .m1_rvalid(c_v1), .m1_rdata(c_rd1),
    .addr(c_addr), .we(c_we), .wdata(c_wd), .rdata(rdata)
  );

  typedef struct {
    logic        rst;
    logic        r0;
    logic [31:0] a0;
    logic        w0;
    logic [31:0] d0;
    logic        r1;
    logic [31:0] a1;
    logic        w1;
    logic [31:0] d1;
    logic [31:0] rd;
    logic        g0, g1, v0, v1;
    logic [31:0] ea;
    logic        ewe;
    logic [31:0] ewd;
  } vec_t;

  vec_t tv[28];

  function automatic vec_t mk(input logic rs, input logic r0, input logic [31:0] a0,
                              input logic w0, input logic [31:0] d0, input logic r1,
                              input logic [31:0] a1, input logic w1, input logic [31:0] d1,
                              input logic [31:0] rd, input logic g0, input logic g1,
                              input logic v0, input logic v1, input logic [31:0] ea,
                              input logic ewe, input logic [31:0] ewd);
    vec_t v;
    v.rst = rs; v.r0 = r0; v.a0 = a0; v.w0 = w0; v.d0 = d0;
    v.r1 = r1; v.a1 = a1; v.w1 = w1; v.d1 = d1; v.rd = rd;
    v.g0 = g0; v.g1 = g1; v.v0 = v0; v.v1 = v1;
    v.ea = ea; v.ewe = ewe; v.ewd = ewd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic rs, input logic r0, input logic [31:0] a0, input logic w0,
                     input logic [31:0] d0, input logic r1, input logic [31:0] a1,
                     input logic w1, input logic [31:0] d1, input logic [31:0] rd);
    @(negedge clk);
    rst = rs;
    m0_req = r0; m0_addr = a0; m0_we = w0; m0_wdata = d0;
    m1_req = r1; m1_addr = a1; m1_we = w1; m1_wdata = d1;
    rdata = rd;
    #1;
  endtask

  task automatic do_reset();
    cyc(1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    // rst  r0 a0       w0 d0      r1 a1       w1 d1       rdata           g0 g1 v0 v1 addr     we wdata
    tv[0]  = mk(1, 1, 32'h10,  0, 0,     1, 32'h20,  1, 32'h55, 32'hA000_0000, 0, 0, 0, 0, 0,       0, 0);
    tv[1]  = mk(1, 1, 32'h10,  0, 0,     1, 32'h20,  1, 32'h55, 32'hA000_0001, 0, 0, 0, 0, 0,       0, 0);
    tv[2]  = mk(0, 1, 32'h10,  0, 0,     1, 32'h20,  1, 32'h55, 32'hA000_0002, 0, 0, 0, 0, 0,       0, 0);
    tv[3]  = mk(0, 1, 32'h10,  0, 0,     1, 32'h20,  1, 32'h55, 32'hA000_0003, 1, 0, 0, 0, 32'h10,  0, 0);
    tv[4]  = mk(0, 0, 0,       0, 0,     1, 32'h20,  1, 32'h55, 32'hDEAD_BEEF, 0, 0, 1, 0, 0,       0, 0);
    tv[5]  = mk(0, 0, 0,       0, 0,     1, 32'h20,  1, 32'h55, 32'hA000_0005, 0, 1, 0, 0, 32'h20,  1, 32'h55);
    tv[6]  = mk(0, 0, 0,       0, 0,     0, 0,       0, 0,      32'hA000_0006, 0, 0, 0, 0, 0,       0, 0);
    tv[7]  = mk(0, 0, 0,       0, 0,     0, 0,       0, 0,      32'hA000_0007, 0, 0, 0, 0, 0,       0, 0);
    tv[8]  = mk(0, 1, 32'h100, 0, 0,     1, 32'h200, 0, 0,      32'hA000_0008, 0, 0, 0, 0, 0,       0, 0);
    tv[9]  = mk(0, 1, 32'h100, 0, 0,     1, 32'h200, 0, 0,      32'hA000_0009, 1, 0, 0, 0, 32'h100, 0, 0);
    tv[10] = mk(0, 1, 32'h100, 0, 0,     1, 32'h200, 0, 0,      32'hA000_000A, 1, 0, 1, 0, 32'h100, 0, 0);
    tv[11] = mk(0, 1, 32'h100, 0, 0,     1, 32'h200, 0, 0,      32'hA000_000B, 1, 0, 1, 0, 32'h100, 0, 0);
    tv[12] = mk(0, 1, 32'h100, 0, 0,     1, 32'h200, 0, 0,      32'hA000_000C, 1, 0, 1, 0, 32'h100, 0, 0);
    tv[13] = mk(0, 1, 32'h100, 0, 0,     1, 32'h200, 0, 0,      32'hA000_000D, 0, 1, 1, 0, 32'h200, 0, 0);
    tv[14] = mk(0, 1, 32'h100, 0, 0,     1, 32'h200, 0, 0,      32'hA000_000E, 0, 1, 0, 1, 32'h200, 0, 0);
    tv[15] = mk(0, 1, 32'h100, 0, 0,     1, 32'h200, 0, 0,      32'hA000_000F, 0, 1, 0, 1, 32'h200, 0, 0);
    tv[16] = mk(0, 1, 32'h100, 0, 0,     1, 32'h200, 0, 0,      32'hA000_0010, 0, 1, 0, 1, 32'h200, 0, 0);
    tv[17] = mk(0, 1, 32'h100, 0, 0,     1, 32'h200, 0, 0,      32'hA000_0011, 1, 0, 0, 1, 32'h100, 0, 0);
    tv[18] = mk(0, 1, 32'h100, 0, 0,     1, 32'h200, 0, 0,      32'hA000_0012, 1, 0, 1, 0, 32'h100, 0, 0);
    tv[19] = mk(0, 1, 32'h100, 0, 0,     1, 32'h200, 0, 0,      32'hA000_0013, 1, 0, 1, 0, 32'h100, 0, 0);
    tv[20] = mk(0, 1, 32'h100, 0, 0,     1, 32'h200, 0, 0,      32'hA000_0014, 1, 0, 1, 0, 32'h100, 0, 0);
    tv[21] = mk(0, 0, 0,       0, 0,     0, 0,       0, 0,      32'hA000_0015, 0, 0, 1, 0, 0,       0, 0);
    tv[22] = mk(0, 0, 0,       0, 0,     0, 0,       0, 0,      32'hA000_0016, 0, 0, 0, 0, 0,       0, 0);
    tv[23] = mk(0, 0, 0,       0, 0,     1, 32'h300, 0, 0,      32'hA000_0017, 0, 0, 0, 0, 0,       0, 0);
    tv[24] = mk(0, 0, 0,       0, 0,     1, 32'h300, 0, 0,      32'hA000_0018, 0, 1, 0, 0, 32'h300, 0, 0);
    tv[25] = mk(0, 1, 32'h40,  1, 32'h77, 0, 0,      0, 0,      32'hA000_0019, 0, 0, 0, 1, 0,       0, 0);
    tv[26] = mk(0, 1, 32'h40,  1, 32'h77, 0, 0,      0, 0,      32'hA000_001A, 1, 0, 0, 0, 32'h40,  1, 32'h77);
    tv[27] = mk(0, 0, 0,       0, 0,     0, 0,       0, 0,      32'hA000_001B, 0, 0, 0, 0, 0,       0, 0);

    // Table on the latency-1, burst-4 instance
    for (int i = 0; i < 28; i++) begin
      cyc(tv[i].rst, tv[i].r0, tv[i].a0, tv[i].w0, tv[i].d0,
          tv[i].r1, tv[i].a1, tv[i].w1, tv[i].d1, tv[i].rd);
      chk($sformatf("v%0d m0_gnt", i),    {31'd0, a_g0}, {31'd0, tv[i].g0});
      chk($sformatf("v%0d m1_gnt", i),    {31'd0, a_g1}, {31'd0, tv[i].g1});
      chk($sformatf("v%0d m0_rvalid", i), {31'd0, a_v0}, {31'd0, tv[i].v0});
      chk($sformatf("v%0d m1_rvalid", i), {31'd0, a_v1}, {31'd0, tv[i].v1});
      chk($sformatf("v%0d m0_rdata", i),  a_rd0, tv[i].v0 ? tv[i].rd : 32'd0);
      chk($sformatf("v%0d m1_rdata", i),  a_rd1, tv[i].v1 ? tv[i].rd : 32'd0);
      chk($sformatf("v%0d addr", i),      a_addr, tv[i].ea);
      chk($sformatf("v%0d we", i),        {31'd0, a_we}, {31'd0, tv[i].ewe});
      chk($sformatf("v%0d wdata", i),     a_wd, tv[i].ewd);
    end

    // Latency 2: m0 reads 0x4, 0x8, then m1 reads 0xC
    do_reset();
    cyc(0, 1, 32'h4, 0, 0, 0, 0,     0, 0, 0);
    chk("l2 c0 m0_gnt", {31'd0, b_g0}, 32'd0);
    cyc(0, 1, 32'h4, 0, 0, 1, 32'hC, 0, 0, 0);
    chk("l2 c1 m0_gnt", {31'd0, b_g0}, 32'd1);
    chk("l2 c1 addr", b_addr, 32'h4);
    cyc(0, 1, 32'h8, 0, 0, 1, 32'hC, 0, 0, 0);
    chk("l2 c2 m0_gnt", {31'd0, b_g0}, 32'd1);
    chk("l2 c2 addr", b_addr, 32'h8);
    chk("l2 c2 m0_rvalid", {31'd0, b_v0}, 32'd0);
    cyc(0, 0, 0, 0, 0, 1, 32'hC, 0, 0, 32'h1111);
    chk("l2 c3 m1_gnt", {31'd0, b_g1}, 32'd0);
    chk("l2 c3 m0_rvalid", {31'd0, b_v0}, 32'd1);
    chk("l2 c3 m0_rdata", b_rd0, 32'h1111);
    chk("l2 c3 m1_rvalid", {31'd0, b_v1}, 32'd0);
    cyc(0, 0, 0, 0, 0, 1, 32'hC, 0, 0, 32'h2222);
    chk("l2 c4 m1_gnt", {31'd0, b_g1}, 32'd1);
    chk("l2 c4 addr", b_addr, 32'hC);
    chk("l2 c4 m0_rvalid", {31'd0, b_v0}, 32'd1);
    chk("l2 c4 m0_rdata", b_rd0, 32'h2222);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h5555);
    chk("l2 c5 m0_rvalid", {31'd0, b_v0}, 32'd0);
    chk("l2 c5 m1_rvalid", {31'd0, b_v1}, 32'd0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h3333);
    chk("l2 c6 m1_rvalid", {31'd0, b_v1}, 32'd1);
    chk("l2 c6 m1_rdata", b_rd1, 32'h3333);
    chk("l2 c6 m0_rvalid", {31'd0, b_v0}, 32'd0);

    // Latency 2: reset right after an m1 read accept drops the read
    do_reset();
    cyc(0, 0, 0, 0, 0, 1, 32'h50, 0, 0, 32'h6666);
    chk("rst c0 m1_gnt", {31'd0, b_g1}, 32'd0);
    cyc(0, 0, 0, 0, 0, 1, 32'h50, 0, 0, 32'h6666);
    chk("rst c1 m1_gnt", {31'd0, b_g1}, 32'd1);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h6666);
    chk("rst c2 m1_rvalid", {31'd0, b_v1}, 32'd0);
    cyc(0, 1, 32'h60, 0, 0, 0, 0, 0, 0, 32'h6666);
    chk("rst c3 m1_rvalid", {31'd0, b_v1}, 32'd0);
    chk("rst c3 m1_rdata", b_rd1, 32'd0);
    chk("rst c3 m0_gnt", {31'd0, b_g0}, 32'd0);
    chk("rst c3 addr", b_addr, 32'd0);
    cyc(0, 1, 32'h60, 0, 0, 0, 0, 0, 0, 32'h6666);
    chk("rst c4 m1_rvalid", {31'd0, b_v1}, 32'd0);
    chk("rst c4 m0_gnt", {31'd0, b_g0}, 32'd1);
    chk("rst c4 addr", b_addr, 32'h60);

    // Burst limit 1: strict alternation under continuous requests
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cyc(0, 1, 32'h70, 0, 0, 1, 32'h80, 0, 0, 0);
      chk($sformatf("mb1 c%0d m0_gnt", i), {31'd0, c_g0}, (i > 0 && (i % 2) == 1) ? 32'd1 : 32'd0);
      chk($sformatf("mb1 c%0d m1_gnt", i), {31'd0, c_g1}, (i > 0 && (i % 2) == 0) ? 32'd1 : 32'd0);
    end

    // Burst counter saturates while alone, so the first contended accept hands over
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, 32'h90, 0, 0, (i >= 6), 32'hA0, 0, 0, 0);
      chk($sformatf("sat c%0d m0_gnt", i), {31'd0, a_g0}, (i >= 1 && i <= 6) ? 32'd1 : 32'd0);
      chk($sformatf("sat c%0d m1_gnt", i), {31'd0, a_g1}, (i == 7) ? 32'd1 : 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
